// File: rtl/spu_issue_scheduler.sv
// In-order dual-issue scheduler: routes a held instruction pair to the even/odd pipes behind a latency-countdown scoreboard.
// Optional macro SPU_SCHED_PERF_CNT_EN adds saturating dual/single/stall performance counters.
module spu_issue_scheduler #(
    parameter int NREG   = 128,
    parameter int LAT_W  = 3,
    parameter int SLOT_W = 37
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pair_valid_i,
    output logic              pair_ready_o,
    input  logic [SLOT_W-1:0] slot1_i,
    input  logic [SLOT_W-1:0] slot2_i,
    input  logic              flush_i,
    output logic              even_issue_o,
    output logic [SLOT_W-1:0] even_inst_o,
    output logic              odd_issue_o,
    output logic [SLOT_W-1:0] odd_inst_o,
    output logic              stall_o
`ifdef SPU_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_dual_o,
    output logic [31:0]       perf_single_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, PAIR, SECOND} stateT;

    stateT             stateQ, stateD;
    logic [SLOT_W-1:0] slot1Q, slot2Q;
    logic [LAT_W-1:0]  cntQ [NREG];
    logic [NREG-1:0]   busy;

    logic s1Issue, s2Issue, complete;
    logic s1Free, s2Free, intraRaw, intraWaw;

    // Descriptor: v[36] pipe[35] we[34] lat[33:31] rt[30:24] ra_use[23] ra[22:16] rb_use[15] rb[14:8] rc_use[7] rc[6:0]
    function automatic logic srcFree(input logic [SLOT_W-1:0] s, input logic [NREG-1:0] b);
        return !(s[23] && b[s[22:16]]) && !(s[15] && b[s[14:8]]) && !(s[7] && b[s[6:0]]);
    endfunction

    function automatic logic readsReg(input logic [SLOT_W-1:0] s, input logic [RW-1:0] r);
        return (s[23] && s[22:16] == r) || (s[15] && s[14:8] == r) || (s[7] && s[6:0] == r);
    endfunction

    always_comb begin
        for (int r = 0; r < NREG; r++) busy[r] = (cntQ[r] != '0);
    end

    assign s1Free   = srcFree(slot1Q, busy);
    assign s2Free   = srcFree(slot2Q, busy);
    assign intraRaw = slot1Q[34] && readsReg(slot2Q, slot1Q[30:24]);
    assign intraWaw = slot1Q[34] && slot2Q[34] && (slot1Q[30:24] == slot2Q[30:24]);

    always_ff @(posedge clk) begin
        if (reset) stateQ <= IDLE;
        else       stateQ <= stateD;
    end

    always_comb begin
        s1Issue  = 1'b0;
        s2Issue  = 1'b0;
        complete = 1'b0;
        stateD   = stateQ;
        case (stateQ)
            PAIR: begin
                // An invalid slot counts as already issued; slot1 blocks slot2 in order.
                if (!slot1Q[36] || s1Free) begin
                    s1Issue  = slot1Q[36];
                    s2Issue  = slot2Q[36] && s2Free &&
                               (!slot1Q[36] || ((slot1Q[35] != slot2Q[35]) && !intraRaw && !intraWaw));
                    complete = s2Issue || !slot2Q[36];
                    if (!complete) stateD = SECOND;
                end
            end
            SECOND: begin
                if (!slot2Q[36] || s2Free) begin
                    s2Issue  = slot2Q[36];
                    complete = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush_i) begin
            s1Issue  = 1'b0;
            s2Issue  = 1'b0;
            complete = 1'b0;
        end
        pair_ready_o = !flush_i && ((stateQ == IDLE) || complete);
        if (complete) stateD = IDLE;
        if (pair_ready_o && pair_valid_i) stateD = PAIR;
        if (flush_i) stateD = IDLE;
    end

    always_comb begin
        even_issue_o = (s1Issue && !slot1Q[35]) || (s2Issue && !slot2Q[35]);
        odd_issue_o  = (s1Issue && slot1Q[35]) || (s2Issue && slot2Q[35]);
        even_inst_o  = '0;
        odd_inst_o   = '0;
        if (s1Issue && !slot1Q[35]) even_inst_o = slot1Q;
        else if (s2Issue && !slot2Q[35]) even_inst_o = slot2Q;
        if (s1Issue && slot1Q[35]) odd_inst_o = slot1Q;
        else if (s2Issue && slot2Q[35]) odd_inst_o = slot2Q;
        stall_o = (stateQ != IDLE) && !(s1Issue || s2Issue);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot1Q <= '0;
            slot2Q <= '0;
        end else if (flush_i) begin
            slot1Q <= '0;
            slot2Q <= '0;
        end else if (pair_valid_i && pair_ready_o) begin
            slot1Q <= slot1_i;
            slot2Q <= slot2_i;
        end
    end

    // Slot2 load wins by position; both loading the same rt is excluded by the WAW rule.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset)
                cntQ[r] <= '0;
            else if (s2Issue && slot2Q[34] && slot2Q[30:24] == RW'(r))
                cntQ[r] <= slot2Q[33:31];
            else if (s1Issue && slot1Q[34] && slot1Q[30:24] == RW'(r))
                cntQ[r] <= slot1Q[33:31];
            else if (cntQ[r] != '0)
                cntQ[r] <= cntQ[r] - LAT_W'(1);
        end
    end

`ifdef SPU_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_dual_o   <= '0;
            perf_single_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (even_issue_o && odd_issue_o && perf_dual_o != '1)
                perf_dual_o <= perf_dual_o + 32'd1;
            if ((even_issue_o ^ odd_issue_o) && perf_single_o != '1)
                perf_single_o <= perf_single_o + 32'd1;
            if (stall_o && perf_stall_o != '1)
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spu_issue_scheduler.sv
// Directed bench for spu_issue_scheduler: expected issued descriptors are queued per test and checked as the DUT issues them.
module tb_spu_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        pair_valid_i;
    logic        pair_ready_o;
    logic [36:0] slot1_i, slot2_i;
    logic        flush_i;
    logic        even_issue_o, odd_issue_o, stall_o;
    logic [36:0] even_inst_o, odd_inst_o;

    logic [37:0] expQ[$];
    int          nVec = 0;
    int          nErr = 0;
    logic        monOn = 1'b0;

    spu_issue_scheduler dut (
        .clk(clk), .reset(reset),
        .pair_valid_i(pair_valid_i), .pair_ready_o(pair_ready_o),
        .slot1_i(slot1_i), .slot2_i(slot2_i), .flush_i(flush_i),
        .even_issue_o(even_issue_o), .even_inst_o(even_inst_o),
        .odd_issue_o(odd_issue_o), .odd_inst_o(odd_inst_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic popCheck(input string tag, input logic [37:0] obs);
        checkVal({tag, "Pending"}, 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) checkVal(tag, 64'(obs), 64'(expQ.pop_front()));
    endtask

    always @(negedge clk) begin
        if (monOn && !reset) begin
            if (even_issue_o) popCheck("evenInst", {1'b0, even_inst_o});
            else checkVal("evenIdleZero", 64'(even_inst_o), 64'd0);
            if (odd_issue_o) popCheck("oddInst", {1'b1, odd_inst_o});
            else checkVal("oddIdleZero", 64'(odd_inst_o), 64'd0);
        end
    end

    function automatic logic [36:0] mk(input logic p, input logic we, input logic [2:0] lat,
                                       input logic [6:0] rt, input logic au, input logic [6:0] a,
                                       input logic bu, input logic [6:0] b, input logic cu,
                                       input logic [6:0] c);
        return {1'b1, p, we, lat, rt, au, a, bu, b, cu, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadPair(input logic [36:0] s1, input logic [36:0] s2);
        pair_valid_i = 1'b1;
        slot1_i      = s1;
        slot2_i      = s2;
        tick();
        pair_valid_i = 1'b0;
    endtask

    task automatic outs(input string tag, input logic e, input logic o, input logic rdy, input logic st);
        checkVal({tag, ".even"}, 64'(even_issue_o), 64'(e));
        checkVal({tag, ".odd"}, 64'(odd_issue_o), 64'(o));
        checkVal({tag, ".ready"}, 64'(pair_ready_o), 64'(rdy));
        checkVal({tag, ".stall"}, 64'(stall_o), 64'(st));
    endtask

    logic [36:0] a1, a2;
    int          nz;

    initial begin
        reset = 1'b1; pair_valid_i = 1'b0; flush_i = 1'b0;
        slot1_i = '0; slot2_i = '0;
        repeat (2) tick();
        reset = 1'b0;
        monOn = 1'b1;
        outs("reset", 0, 0, 1, 0);

        // dual issue to different pipes, scoreboard loaded with each lat
        a1 = mk(0, 1, 2, 3, 1, 1, 1, 2, 0, 0);
        a2 = mk(1, 1, 6, 5, 1, 4, 0, 0, 0, 0);
        loadPair(a1, a2);
        expQ.push_back({1'b0, a1}); expQ.push_back({1'b1, a2});
        outs("dual", 1, 1, 1, 0);
        tick();
        checkVal("dual.cnt3", 64'(dut.cntQ[3]), 64'd2);
        checkVal("dual.cnt5", 64'(dut.cntQ[5]), 64'd6);
        outs("dualIdle", 0, 0, 1, 0);
        repeat (8) tick();

        // intra-pair RAW: slot2 waits out slot1's latency
        a1 = mk(0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        a2 = mk(1, 1, 1, 9, 1, 3, 0, 0, 0, 0);
        loadPair(a1, a2);
        expQ.push_back({1'b0, a1});
        outs("raw.n", 1, 0, 0, 0);
        tick(); outs("raw.n1", 0, 0, 0, 1);
        tick(); outs("raw.n2", 0, 0, 0, 1);
        tick(); expQ.push_back({1'b1, a2});
        outs("raw.n3", 0, 1, 1, 0);
        repeat (8) tick();

        // structural: both on even pipe
        a1 = mk(0, 0, 0, 11, 0, 0, 0, 0, 0, 0);
        a2 = mk(0, 0, 0, 12, 1, 1, 0, 0, 0, 0);
        loadPair(a1, a2);
        expQ.push_back({1'b0, a1});
        outs("struct.n", 1, 0, 0, 0);
        tick(); expQ.push_back({1'b0, a2});
        outs("struct.n1", 1, 0, 1, 0);
        repeat (2) tick();

        // scoreboard stall, with zero-bubble capture behind a single-slot pair
        a1 = mk(1, 1, 6, 10, 0, 0, 0, 0, 0, 0);
        loadPair(a1, '0);
        expQ.push_back({1'b1, a1});
        outs("sbLoad", 0, 1, 1, 0);
        a1 = mk(0, 1, 1, 13, 0, 0, 1, 10, 0, 0);
        a2 = mk(1, 0, 0, 14, 0, 0, 0, 0, 0, 0);
        loadPair(a1, a2);
        for (int i = 0; i < 6; i++) begin
            outs($sformatf("sbStall%0d", i), 0, 0, 0, 1);
            tick();
        end
        expQ.push_back({1'b0, a1}); expQ.push_back({1'b1, a2});
        outs("sbGo", 1, 1, 1, 0);
        repeat (8) tick();

        // same destination: sequential issue, slot2's lat survives
        a1 = mk(0, 1, 2, 7, 0, 0, 0, 0, 0, 0);
        a2 = mk(1, 1, 5, 7, 0, 0, 0, 0, 0, 0);
        loadPair(a1, a2);
        expQ.push_back({1'b0, a1});
        outs("waw.n", 1, 0, 0, 0);
        tick(); expQ.push_back({1'b1, a2});
        outs("waw.n1", 0, 1, 1, 0);
        tick();
        checkVal("waw.cnt7", 64'(dut.cntQ[7]), 64'd5);
        repeat (8) tick();

        // flush while in SECOND: dropped slot2 must never issue
        a1 = mk(0, 1, 4, 3, 0, 0, 0, 0, 0, 0);
        a2 = mk(1, 0, 0, 9, 1, 3, 0, 0, 0, 0);
        loadPair(a1, a2);
        expQ.push_back({1'b0, a1});
        tick();
        outs("flushPre", 0, 0, 0, 1);
        flush_i = 1'b1; #1;
        checkVal("flush.even", 64'(even_issue_o), 64'd0);
        checkVal("flush.odd", 64'(odd_issue_o), 64'd0);
        checkVal("flush.ready", 64'(pair_ready_o), 64'd0);
        tick(); flush_i = 1'b0; #1;
        outs("postFlush", 0, 0, 1, 0);
        checkVal("postFlush.cnt3", 64'(dut.cntQ[3]), 64'd3);
        tick();
        checkVal("postFlush.cnt3b", 64'(dut.cntQ[3]), 64'd2);
        flush_i = 1'b1; #1;
        checkVal("flushIdle.ready", 64'(pair_ready_o), 64'd0);
        flush_i = 1'b0;
        repeat (6) tick();

        // reset mid-pair clears state and scoreboard
        a1 = mk(0, 1, 5, 20, 0, 0, 0, 0, 0, 0);
        a2 = mk(1, 0, 0, 9, 1, 20, 0, 0, 0, 0);
        loadPair(a1, a2);
        expQ.push_back({1'b0, a1});
        outs("rst.n", 1, 0, 0, 0);
        tick();
        checkVal("rst.cnt20pre", 64'(dut.cntQ[20]), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        outs("rst.after", 0, 0, 1, 0);
        checkVal("rst.cnt20", 64'(dut.cntQ[20]), 64'd0);
        nz = 0;
        for (int r = 0; r < 128; r++) if (dut.cntQ[r] != 3'd0) nz++;
        checkVal("rst.cntAllZero", 64'(nz), 64'd0);
        a1 = mk(0, 0, 0, 21, 1, 20, 0, 0, 0, 0);
        loadPair(a1, '0);
        expQ.push_back({1'b0, a1});
        outs("rst.reader", 1, 0, 1, 0);
        repeat (3) tick();

        checkVal("expQEmpty", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/spu_issue_scheduler.md
Name: spu_issue_scheduler

Overview:
- In-order dual-issue scheduler between the IF_ID pair register and the ID/REG stage of the SPU pipeline.
- Each cycle it decides which of the held instruction pair (slot1 older, slot2 younger) issues to the even pipe and which to the odd pipe.
- It tracks in-flight destination registers in a latency-countdown scoreboard and serialises the pair on RAW, structural and same-destination hazards.
- It replaces the ad-hoc nop generation from the forwarding units.

Parameters:
- NREG, 128, architectural register count; scoreboard depth.
- LAT_W, 3, latency/counter width; max latency 7.
- SLOT_W, 37, packed slot descriptor width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pair_valid_i  in  1  IF_ID presents a new pair.
- pair_ready_o  out  1  scheduler accepts the pair this cycle.
- slot1_i  in  SLOT_W  older instruction descriptor.
- slot2_i  in  SLOT_W  younger instruction descriptor.
- flush_i  in  1  discard the held pair (branch redirect).
- even_issue_o  out  1  even pipe issues this cycle.
- even_inst_o  out  SLOT_W  descriptor issued to the even pipe.
- odd_issue_o  out  1  odd pipe issues this cycle.
- odd_inst_o  out  SLOT_W  descriptor issued to the odd pipe.
- stall_o  out  1  a pair is held and nothing issued this cycle.

Slot descriptor layout, MSB to LSB:
- v[36], pipe[35] (0 even, 1 odd), we[34], lat[33:31].
- rt[30:24], ra_use[23], ra[22:16], rb_use[15], rb[14:8], rc_use[7], rc[6:0].

Behaviour:
- Reset: state IDLE, held pair cleared, all scoreboard counters 0. All outputs 0 except pair_ready_o=1.
- States:
  - IDLE: no pair held.
  - PAIR: both slots pending.
  - SECOND: slot1 done, slot2 pending.
- Capture: on pair_valid_i & pair_ready_o, slot1_i and slot2_i are latched; next state is PAIR.
- Issue outputs and pair_ready_o are combinational from registered state, held pair and scoreboard only, with flush_i as a gate. There is no path from pair_valid_i or slot inputs to outputs.
- Scoreboard: cnt[r], LAT_W bits per register.
  - Decrements by 1 each cycle while nonzero.
  - An issue with we=1 loads cnt[rt]=lat; the load overrides the decrement.
  - lat=0 leaves no entry.
- Ready rule: a slot is hazard-free when every used source (ra/rb/rc with _use=1) has cnt==0.
- WAW against the scoreboard is not a hazard: writeback is in-order at fixed depth. The newest issue overwrites cnt.
- A slot with v=0 is treated as already issued.
- PAIR decision:
  - If slot1 is not hazard-free: stall both (in-order) and stay in PAIR.
  - Otherwise slot1 issues to its pipe.
  - slot2 issues in the same cycle only if all hold: v=1, pipe differs from slot1, slot2 is hazard-free, slot2 reads no source equal to slot1.rt while slot1.we=1, and not (both we and equal rt).
  - If both issue (or slot2 v=0): the pair is complete. Otherwise next state is SECOND.
- SECOND: slot2 issues when hazard-free; the pair is then complete.
- Completion: pair_ready_o=1 in the completing cycle, so a new pair is captured with zero bubbles. Without pair_valid_i, next state is IDLE.
- IDLE: pair_ready_o=1, stall_o=0, no issue.
- Routing: a slot with pipe=0 drives even_*, pipe=1 drives odd_*. The unused output descriptor is driven 0.
- stall_o=1 in PAIR or SECOND when no issue occurs.
- flush_i has priority over everything except reset:
  - Issue outputs and pair_ready_o are forced to 0 that cycle.
  - The held pair is dropped; next state is IDLE.
  - The scoreboard keeps decrementing, since in-flight instructions complete.
- Reset mid-pair: state and scoreboard cleared on the next edge regardless of other inputs.

Optional Feature:
- Macro: SPU_SCHED_PERF_CNT_EN.
- When defined, three 32-bit saturating counters are added, all cleared by reset:
  - perf_dual_o: cycles with both pipes issuing.
  - perf_single_o: cycles with exactly one pipe issuing.
  - perf_stall_o: cycles with stall_o=1.
- When undefined, these ports and the counter logic are absent. Core behaviour is identical in both cases.

Test Plan:
- Dual issue: slot1={even, we, rt=3, ra=1, rb=2, lat=2}, slot2={odd, we, rt=5, ra=4, lat=6}, empty scoreboard -> both issue in the cycle after capture; pair_ready_o=1 in the same cycle; next cycle cnt[3]=2, cnt[5]=6.
- Intra-pair RAW: slot1 even writes rt=3 with lat=2; slot2 odd reads ra=3 -> cycle N slot1 issues and state becomes SECOND; slot2 stalls for 2 cycles (stall_o=1); odd_issue_o=1 at N+3.
- Structural conflict: both slots pipe=0 with no dependency -> slot1 issues at N and slot2 at N+1, both on even_issue_o.
- Scoreboard stall: an earlier issue set cnt[10]=6; the new pair's slot1 reads rb=10 -> no issue and stall_o=1 for 6 cycles; slot1 issues on the 7th; slot2 is held back in-order.
- Same-destination pair: both we with rt=7 on different pipes -> sequential issue; cnt[7] ends loaded with slot2.lat.
- Flush and reset: flush_i asserted while in SECOND -> no issue that cycle, next state IDLE with pair_ready_o=1, nonzero cnt entries keep counting down. Reset with cnt[20]=5 -> next cycle all cnt=0, pair_ready_o=1, issue outputs 0.
